// File: rtl/mux_scan_reg.sv
// Registered N-channel, W-bit multiplexer with manual select, timed auto-scan and hold.
// All outputs are registered; the scan index advances after DWELL cycles per channel.
module mux_scan_reg #(
    parameter int WIDTH    = 2,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          sel,
    input  logic [1:0]                mode,
    output logic [WIDTH-1:0]          data_out,
    output logic [SEL_W-1:0]          chan_out,
    output logic                      valid,
    output logic                      sel_err,
    output logic                      wrap
);

    localparam int               CNT_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SEL_W:0]   NUM_CH     = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;

    logic [WIDTH-1:0] data_d, data_q;
    logic [SEL_W-1:0] chan_d, chan_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             valid_d, valid_q;
    logic             err_d, err_q;
    logic             wrap_d, wrap_q;
    logic             sel_ok, chan_ok;

    // Indices that do not name a real channel yield zero instead of reading past the bus.
    function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] bus,
                                              input logic [SEL_W-1:0] idx);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx == SEL_W'(k)) r = bus[k*WIDTH +: WIDTH];
        end
        return r;
    endfunction

    assign sel_ok  = {1'b0, sel} < NUM_CH;
    assign chan_ok = {1'b0, chan_q} < NUM_CH;

    always_comb begin
        data_d  = data_q;
        chan_d  = chan_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        err_d   = err_q;
        wrap_d  = 1'b0;
        case (mode)
            MODE_MANUAL: begin
                chan_d  = sel;
                data_d  = sel_ok ? pick(data_in, sel) : '0;
                valid_d = sel_ok;
                err_d   = ~sel_ok;
                cnt_d   = '0;
            end
            MODE_SCAN: begin
                valid_d = 1'b1;
                err_d   = 1'b0;
                if (!chan_ok) begin
                    // A stale out-of-range manual index restarts the scan at channel 0.
                    chan_d = '0;
                    cnt_d  = '0;
                    data_d = pick(data_in, '0);
                end else begin
                    data_d = pick(data_in, chan_q);
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d = '0;
                        if (chan_q == LAST_CH) begin
                            chan_d = '0;
                            wrap_d = 1'b1;
                        end else begin
                            chan_d = chan_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            chan_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            chan_q  <= chan_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
        end
    end

    assign data_out = data_q;
    assign chan_out = chan_q;
    assign valid    = valid_q;
    assign sel_err  = err_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Directed bench for mux_scan_reg: default 4-channel instance plus a 3-channel instance
// for the out-of-range select path.
module tb_mux_scan_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic [1:0] sel;
    logic [1:0] mode;
    logic [1:0] data_out;
    logic [1:0] chan_out;
    logic       valid, sel_err, wrap;

    logic       rst3_n;
    logic [5:0] data3;
    logic [1:0] sel3;
    logic [1:0] mode3;
    logic [1:0] data_out3;
    logic [1:0] chan_out3;
    logic       valid3, sel_err3, wrap3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mux_scan_reg #(.WIDTH(2), .CHANNELS(4), .SEL_W(2), .DWELL(3)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .sel(sel), .mode(mode),
        .data_out(data_out), .chan_out(chan_out), .valid(valid),
        .sel_err(sel_err), .wrap(wrap)
    );

    mux_scan_reg #(.WIDTH(2), .CHANNELS(3), .SEL_W(2), .DWELL(3)) dut3 (
        .clk(clk), .rst_n(rst3_n), .data_in(data3), .sel(sel3), .mode(mode3),
        .data_out(data_out3), .chan_out(chan_out3), .valid(valid3),
        .sel_err(sel_err3), .wrap(wrap3)
    );

    typedef struct {
        logic [7:0] din;
        logic [1:0] sel;
        logic [1:0] mode;
        logic [1:0] e_data;
        logic [1:0] e_chan;
        logic       e_valid;
        logic       e_err;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [1:0] d, input logic [1:0] c,
                             input logic v, input logic e, input logic w);
        check({tag, ".data"},  32'(data_out), 32'(d));
        check({tag, ".chan"},  32'(chan_out), 32'(c));
        check({tag, ".valid"}, 32'(valid),    32'(v));
        check({tag, ".err"},   32'(sel_err),  32'(e));
        check({tag, ".wrap"},  32'(wrap),     32'(w));
    endtask

    task automatic check3(input string tag, input logic [1:0] d, input logic [1:0] c,
                          input logic v, input logic e, input logic w);
        check({tag, ".data"},  32'(data_out3), 32'(d));
        check({tag, ".chan"},  32'(chan_out3), 32'(c));
        check({tag, ".valid"}, 32'(valid3),    32'(v));
        check({tag, ".err"},   32'(sel_err3),  32'(e));
        check({tag, ".wrap"},  32'(wrap3),     32'(w));
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        // Manual sweep vectors, continuing from chan 2 / data 2 after reset release.
        vecs[0] = '{8'hE4, 2'd0, 2'b00, 2'd0, 2'd0, 1'b1, 1'b0};
        vecs[1] = '{8'hE4, 2'd1, 2'b00, 2'd1, 2'd1, 1'b1, 1'b0};
        vecs[2] = '{8'hE4, 2'd2, 2'b00, 2'd2, 2'd2, 1'b1, 1'b0};
        vecs[3] = '{8'hE4, 2'd3, 2'b00, 2'd3, 2'd3, 1'b1, 1'b0};
        vecs[4] = '{8'h24, 2'd3, 2'b00, 2'd0, 2'd3, 1'b1, 1'b0};
        vecs[5] = '{8'h24, 2'd1, 2'b00, 2'd1, 2'd1, 1'b1, 1'b0};
        vecs[6] = '{8'hE4, 2'd0, 2'b10, 2'd1, 2'd1, 1'b1, 1'b0};
        vecs[7] = '{8'h1B, 2'd2, 2'b11, 2'd1, 2'd1, 1'b1, 1'b0};
        vecs[8] = '{8'hE4, 2'd2, 2'b00, 2'd2, 2'd2, 1'b1, 1'b0};

        rst_n = 1'b0; data_in = 8'hE4; mode = 2'b00; sel = 2'd2;
        rst3_n = 1'b0; data3 = 6'h27; mode3 = 2'b00; sel3 = 2'd3;

        // Reset holds through clock edges
        #22;
        check_all("reset", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        rst3_n = 1'b1;
        step();
        check_all("release", 2'd2, 2'd2, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 9; i++) begin
            data_in = vecs[i].din; sel = vecs[i].sel; mode = vecs[i].mode;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_chan,
                      vecs[i].e_valid, vecs[i].e_err, 1'b0);
        end

        // Scan from reset: chan = (n/3)%4, data lags one edge, wrap every 12 edges
        data_in = 8'hE4; mode = 2'b01;
        pulse_reset();
        for (int n = 1; n <= 24; n++) begin
            step();
            check_all($sformatf("scan%0d", n), 2'(((n - 1) / 3) % 4), 2'((n / 3) % 4),
                      1'b1, 1'b0, (n % 12) == 0);
        end

        // Hold at chan 2 with dwell count 1 (7 edges after reset)
        pulse_reset();
        for (int n = 1; n <= 7; n++) step();
        check_all("pre_hold", 2'd2, 2'd2, 1'b1, 1'b0, 1'b0);
        mode = 2'b10;
        for (int n = 0; n < 3; n++) begin
            data_in = (n % 2 == 0) ? 8'h1B : 8'h00;
            step();
            check_all($sformatf("hold%0d", n), 2'd2, 2'd2, 1'b1, 1'b0, 1'b0);
        end
        data_in = 8'h1B;
        mode = 2'b01;
        step();
        check_all("resume0", 2'd1, 2'd2, 1'b1, 1'b0, 1'b0);
        data_in = 8'hE4;
        step();
        check_all("resume1", 2'd2, 2'd3, 1'b1, 1'b0, 1'b0);
        step();
        check_all("resume2", 2'd3, 2'd3, 1'b1, 1'b0, 1'b0);

        // Async reset mid-scan at chan 3
        pulse_reset();
        for (int n = 1; n <= 9; n++) step();
        check_all("pre_areset", 2'd2, 2'd3, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("areset", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            step();
            check_all($sformatf("restart%0d", n), 2'(((n - 1) / 3) % 4), 2'((n / 3) % 4),
                      1'b1, 1'b0, 1'b0);
        end

        // Error path on the 3-channel instance: ch0=3, ch1=1, ch2=2
        check3("err_sel3", 2'd0, 2'd3, 1'b0, 1'b1, 1'b0);
        mode3 = 2'b01;
        step();
        check3("err_fix", 2'd3, 2'd0, 1'b1, 1'b0, 1'b0);
        for (int m = 1; m <= 9; m++) begin
            logic [1:0] exp_d;
            case (((m - 1) / 3) % 3)
                0:       exp_d = 2'd3;
                1:       exp_d = 2'd1;
                default: exp_d = 2'd2;
            endcase
            step();
            check3($sformatf("scan3_%0d", m), exp_d, 2'((m / 3) % 3), 1'b1, 1'b0,
                   (m % 9) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
